// File: rtl/ifft64_pkg.sv
// ifft64_pkg
//   Shared constants and types for the 64-point IFFT frame packer.
//   SAMPLE_W  : width of one real or imaginary sample
//   FRAME_CYC : sample pairs per frame (one per cycle)
//   FRAME_W   : bits in one packed bank word (FRAME_CYC * SAMPLE_W)
//   ADDR_W    : bank frame-address width
//   Optional feature macro used by the packer: IFFT_PACK_DROP_CNT_EN
package ifft64_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int FRAME_CYC   = 32;
    localparam int FRAME_W     = SAMPLE_W * FRAME_CYC;
    localparam int ADDR_W      = 10;
    localparam int CNT_W       = 10;
    localparam int DROP_W      = 16;
    localparam int CYC_W       = $clog2(FRAME_CYC);
    // out0_re, out0_im, out1_re, out1_im
    localparam int NUM_STREAMS = 4;

    typedef logic [FRAME_W-1:0] ifft_word_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // Next sequential bank address, wrapping after num-1.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a,
                                                    input int unsigned     num);
        return (a == ADDR_W'(num - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/ifft64_frame_shreg.sv
// ifft64_frame_shreg
//   Collect register for one sample stream. Each accepted sample is written
//   into slot i_idx, so slot k occupies bits [W*k+W-1 : W*k].
//   o_frame presents the register with the current write already merged in,
//   which lets the owner capture a completed frame on the same edge that
//   accepts its last sample.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   i_we      : write enable (sample valid)
//   i_idx     : slot index of the incoming sample
//   i_din     : incoming sample
//   o_frame   : collect contents including the in-flight sample
import ifft64_pkg::*;

module ifft64_frame_shreg #(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = FRAME_CYC,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_we,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic [W-1:0]         i_din,
    output logic [W*DEPTH-1:0]   o_frame
);

    logic [W*DEPTH-1:0] r_word;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_word <= '0;
        end else if (i_we) begin
            r_word[i_idx*W +: W] <= i_din;
        end
    end

    always_comb begin
        o_frame = r_word;
        if (i_we) begin
            o_frame[i_idx*W +: W] = i_din;
        end
    end

endmodule

// File: rtl/ifft64_out_packer.sv
// ifft64_out_packer
//   Collects the two-sample-per-cycle IFFT result stream into 32-cycle frames,
//   packs each frame into four 512-bit bank words and writes them to a result
//   bank at a sequential, wrapping frame address. A collect stage and a hold
//   stage overlap, so a new frame can fill while the previous one waits for
//   the bank.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   in_valid            : sample pair valid (core start_check)
//   in0_re..in1_im      : IFFT output samples
//   wr_valid/wr_ready   : bank write handshake
//   wr_addr             : bank frame address
//   wr_out0_re..1_im    : packed frame words (sample k at bits [16k+15:16k])
//   frame_cnt           : frames written, modulo 1024
//   overflow            : sticky, a completed frame was dropped
//   drop_cnt            : saturating dropped-frame count
//                         (only with IFFT_PACK_DROP_CNT_EN defined)
import ifft64_pkg::*;

module ifft64_out_packer #(
    parameter int NUM_FRAMES = 1000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic [SAMPLE_W-1:0]  in0_re,
    input  logic [SAMPLE_W-1:0]  in0_im,
    input  logic [SAMPLE_W-1:0]  in1_re,
    input  logic [SAMPLE_W-1:0]  in1_im,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDR_W-1:0]    wr_addr,
    output ifft_word_t           wr_out0_re,
    output ifft_word_t           wr_out0_im,
    output ifft_word_t           wr_out1_re,
    output ifft_word_t           wr_out1_im,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 overflow
`ifdef IFFT_PACK_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]    drop_cnt
`endif
);

    logic [CYC_W-1:0]                         r_cyc;
    hold_state_t                              r_state;
    hold_state_t                              w_state_nxt;
    logic                                     w_wr_valid;
    logic                                     w_last;
    logic                                     w_hs;
    logic                                     w_xfer;
    logic                                     w_drop;
    logic [NUM_STREAMS-1:0][SAMPLE_W-1:0]     w_din;
    logic [NUM_STREAMS-1:0][FRAME_W-1:0]      w_frame;
    logic [NUM_STREAMS-1:0][FRAME_W-1:0]      r_hold;
    logic [ADDR_W-1:0]                        r_addr;
    logic [CNT_W-1:0]                         r_frame_cnt;
    logic                                     r_overflow;

    assign w_din = {in1_im, in1_re, in0_im, in0_re};

    // Frame completes on the sample accepted in the last slot. The hold stage
    // can take it when empty or when its current word leaves this same edge;
    // otherwise the new frame is lost and the held word stays untouched.
    assign w_last = in_valid && (r_cyc == CYC_W'(FRAME_CYC - 1));
    assign w_hs   = w_wr_valid && wr_ready;
    assign w_xfer = w_last && ((r_state == HOLD_EMPTY) || w_hs);
    assign w_drop = w_last && !w_xfer;

    // ---------------------------------------------------------------- collect
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cyc <= '0;
        end else if (in_valid) begin
            r_cyc <= w_last ? '0 : r_cyc + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stream
        ifft64_frame_shreg #(
            .W     (SAMPLE_W),
            .DEPTH (FRAME_CYC),
            .IDX_W (CYC_W)
        ) u_shreg (
            .CLK     (CLK),
            .RST     (RST),
            .i_we    (in_valid),
            .i_idx   (r_cyc),
            .i_din   (w_din[g]),
            .o_frame (w_frame[g])
        );
    end

    // ------------------------------------------------------------- hold FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= HOLD_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HOLD_EMPTY: if (w_xfer) w_state_nxt = HOLD_FULL;
            HOLD_FULL:  if (w_hs && !w_xfer) w_state_nxt = HOLD_EMPTY;
            default:    w_state_nxt = HOLD_EMPTY;
        endcase
    end

    // wr_valid is a pure decode of registered state, never of wr_ready.
    always_comb begin
        w_wr_valid = (r_state == HOLD_FULL);
    end

    // ------------------------------------------------------------ hold data
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold <= '0;
        end else if (w_xfer) begin
            r_hold <= w_frame;
        end
    end

    // ------------------------------------------------ address / statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr      <= '0;
            r_frame_cnt <= '0;
        end else if (w_hs) begin
            r_addr      <= addr_inc(r_addr, NUM_FRAMES);
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef IFFT_PACK_DROP_CNT_EN
    logic [DROP_W-1:0] r_drop_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign wr_valid   = w_wr_valid;
    assign wr_addr    = r_addr;
    assign wr_out0_re = r_hold[0];
    assign wr_out0_im = r_hold[1];
    assign wr_out1_re = r_hold[2];
    assign wr_out1_im = r_hold[3];
    assign frame_cnt  = r_frame_cnt;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ifft64_out_packer.sv
module tb_ifft64_out_packer;

    typedef logic [3:0][31:0][15:0] frame_t;   // [stream][sample k][bits]
    typedef struct packed {
        logic [9:0]        addr;
        logic [3:0][511:0] w;
    } cap_t;

    logic         CLK;
    logic         RST;
    logic         in_valid;
    logic [15:0]  in0_re, in0_im, in1_re, in1_im;
    logic         wr_ready;

    logic         wr_valid;
    logic [9:0]   wr_addr;
    logic [511:0] wr_out0_re, wr_out0_im, wr_out1_re, wr_out1_im;
    logic [9:0]   frame_cnt;
    logic         overflow;

    logic         w4_valid;
    logic [9:0]   w4_addr;
    logic [511:0] w4_o0r, w4_o0i, w4_o1r, w4_o1i;
    logic [9:0]   w4_frame_cnt;
    logic         w4_overflow;
`ifdef IFFT_PACK_DROP_CNT_EN
    logic [15:0]  drop_cnt;
    logic [15:0]  w4_drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;   // writes expected on the main DUT since its last reset

    cap_t q_main[$];
    cap_t q_w4[$];

    ifft64_out_packer #(.NUM_FRAMES(1000)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid),
        .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_out0_re(wr_out0_re), .wr_out0_im(wr_out0_im),
        .wr_out1_re(wr_out1_re), .wr_out1_im(wr_out1_im),
        .frame_cnt(frame_cnt), .overflow(overflow)
`ifdef IFFT_PACK_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    ifft64_out_packer #(.NUM_FRAMES(4)) dut4 (
        .CLK(CLK), .RST(RST), .in_valid(in_valid),
        .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
        .wr_valid(w4_valid), .wr_ready(wr_ready), .wr_addr(w4_addr),
        .wr_out0_re(w4_o0r), .wr_out0_im(w4_o0i),
        .wr_out1_re(w4_o1r), .wr_out1_im(w4_o1i),
        .frame_cnt(w4_frame_cnt), .overflow(w4_overflow)
`ifdef IFFT_PACK_DROP_CNT_EN
        , .drop_cnt(w4_drop_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Record every completed write; inputs change just after posedge, so the
    // values seen at negedge are the ones the next posedge acts on.
    always @(negedge CLK) begin
        cap_t c;
        if (!RST && wr_valid && wr_ready) begin
            c.addr = wr_addr;
            c.w    = {wr_out1_im, wr_out1_re, wr_out0_im, wr_out0_re};
            q_main.push_back(c);
        end
        if (!RST && w4_valid && wr_ready) begin
            c.addr = w4_addr;
            c.w    = {w4_o1i, w4_o1r, w4_o0i, w4_o0r};
            q_w4.push_back(c);
        end
    end

    // Reference packing: sample k of a stream sits at bits [16k+15:16k].
    function automatic logic [511:0] pack(input frame_t f, input int s);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[16*k +: 16] = f[s][k];
        return r;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 32; k++) f[s][k] = 16'($urandom);
        return f;
    endfunction

    task automatic set_sample(input frame_t f, input int k);
        in0_re = f[0][k]; in0_im = f[1][k]; in1_re = f[2][k]; in1_im = f[3][k];
    endtask

    task automatic junk_inputs();
        in0_re = 16'($urandom); in0_im = 16'($urandom);
        in1_re = 16'($urandom); in1_im = 16'($urandom);
    endtask

    task automatic drive_frame(input frame_t f);
        for (int k = 0; k < 32; k++) begin
            @(posedge CLK); #1;
            in_valid = 1'b1;
            set_sample(f, k);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            in_valid = 1'b0;
            junk_inputs();
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            RST = 1'b1;
            in_valid = 1'($urandom);
            wr_ready = 1'($urandom);
            junk_inputs();
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        in_valid = 1'b0;
        n_hs = 0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        do_reset(4);
        // still inside the window where reset was applied with random inputs
        @(negedge CLK);
        n_checks++;
        if ({wr_valid, wr_addr, frame_cnt, overflow} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b addr=%0d cnt=%0d ovf=%b, want all 0",
                     wr_valid, wr_addr, frame_cnt, overflow);
        end
        n_checks++;
        if ({wr_out0_re, wr_out0_im, wr_out1_re, wr_out1_im} !== 2048'd0) begin
            n_fail++;
            $display("FAIL reset_data: wr_out words not all zero");
        end
        n_checks++;
        if ({w4_valid, w4_addr, w4_frame_cnt, w4_overflow} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl_w4: valid=%b addr=%0d cnt=%0d", w4_valid, w4_addr, w4_frame_cnt);
        end
`ifdef IFFT_PACK_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_single_frame();
        frame_t f;
        f = rand_frame();
        for (int k = 0; k < 32; k++) begin
            f[0][k] = 16'(k);
            f[3][k] = 16'h8000 | 16'(k);
        end
        wr_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge CLK); #1;
            in_valid = 1'b1;
            set_sample(f, k);
            @(negedge CLK);
            n_checks++;
            if (wr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early_valid: k=%0d wr_valid=%b want 0", k, wr_valid);
            end
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL single_valid: wr_valid=%b addr=%0d want 1/0", wr_valid, wr_addr);
        end
        n_checks++;
        if (wr_out0_re !== pack(f, 0)) begin
            n_fail++;
            $display("FAIL single_out0_re: got %h want %h", wr_out0_re, pack(f, 0));
        end
        n_checks++;
        if (wr_out1_im !== pack(f, 3)) begin
            n_fail++;
            $display("FAIL single_out1_im: got %h want %h", wr_out1_im, pack(f, 3));
        end
        n_checks++;
        if (wr_out0_im !== pack(f, 1) || wr_out1_re !== pack(f, 2)) begin
            n_fail++;
            $display("FAIL single_out_other: out0_im/out1_re packing wrong");
        end
        n_hs++;
        @(negedge CLK);
        n_checks++;
        if (wr_valid !== 1'b0 || frame_cnt !== 10'd1) begin
            n_fail++;
            $display("FAIL single_after: wr_valid=%b frame_cnt=%0d want 0/1", wr_valid, frame_cnt);
        end
    endtask

    task automatic test_gapped();
        frame_t f;
        f = rand_frame();
        for (int k = 0; k < 32; k++) begin
            f[0][k] = 16'(k);
            f[3][k] = 16'h8000 | 16'(k);
        end
        wr_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(posedge CLK); #1;
            in_valid = 1'b1;
            set_sample(f, k);
            @(negedge CLK);
            n_checks++;
            if (wr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_early_valid: k=%0d wr_valid=%b want 0", k, wr_valid);
            end
            @(posedge CLK); #1;
            in_valid = 1'b0;
            junk_inputs();
            @(negedge CLK);
            n_checks++;
            if (wr_valid !== (k == 31)) begin
                n_fail++;
                $display("FAIL gap_valid: k=%0d wr_valid=%b want %b", k, wr_valid, (k == 31));
            end
        end
        n_checks++;
        if (wr_addr !== 10'(n_hs % 1000) || wr_out0_re !== pack(f, 0) || wr_out1_im !== pack(f, 3)
            || wr_out0_im !== pack(f, 1) || wr_out1_re !== pack(f, 2)) begin
            n_fail++;
            $display("FAIL gap_data: addr=%0d want %0d, out0_re=%h", wr_addr, n_hs % 1000, wr_out0_re);
        end
        n_hs++;
        @(negedge CLK);
        n_checks++;
        if (frame_cnt !== 10'(n_hs % 1024)) begin
            n_fail++;
            $display("FAIL gap_frame_cnt: got %0d want %0d", frame_cnt, n_hs % 1024);
        end
    endtask

    task automatic test_back_to_back();
        frame_t f[3];
        int     base;
        base = n_hs;
        q_main.delete();
        wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) f[i] = rand_frame();
        for (int i = 0; i < 3; i++) drive_frame(f[i]);
        idle(4);
        n_hs += 3;
        n_checks++;
        if (q_main.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d writes want 3", q_main.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_main[i].addr !== 10'((base + i) % 1000) ||
                    q_main[i].w !== {pack(f[i], 3), pack(f[i], 2), pack(f[i], 1), pack(f[i], 0)}) begin
                    n_fail++;
                    $display("FAIL b2b_write%0d: addr=%0d want %0d (or data wrong)",
                             i, q_main[i].addr, (base + i) % 1000);
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b0 || frame_cnt !== 10'(n_hs % 1024)) begin
            n_fail++;
            $display("FAIL b2b_status: ovf=%b cnt=%0d want 0/%0d", overflow, frame_cnt, n_hs % 1024);
        end
    endtask

    task automatic test_backpressure();
        frame_t f0, f1, f2;
        int     base;
        f0 = rand_frame(); f1 = rand_frame(); f2 = rand_frame();
        base = n_hs;
        q_main.delete();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pre_overflow: got %b want 0", overflow);
        end
        wr_ready = 1'b0;
        fork
            begin
                drive_frame(f0);
                drive_frame(f1);
                drive_frame(f2);
                idle(1);
            end
            begin
                int t;
                t = 0;
                while (wr_valid !== 1'b1 && t < 200) begin
                    @(negedge CLK);
                    t++;
                end
                if (wr_valid !== 1'b1) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bp_timeout: wr_valid never rose");
                end else begin
                    for (int i = 0; i < 40; i++) begin
                        n_checks++;
                        if (wr_valid !== 1'b1 || wr_addr !== 10'(base % 1000) ||
                            wr_out0_re !== pack(f0, 0) || wr_out1_im !== pack(f0, 3)) begin
                            n_fail++;
                            $display("FAIL bp_hold_stable: cycle %0d valid=%b addr=%0d want 1/%0d",
                                     i, wr_valid, wr_addr, base % 1000);
                        end
                        @(negedge CLK);
                    end
                end
                @(posedge CLK); #1;
                wr_ready = 1'b1;
            end
        join
        idle(40);
        n_hs += 2;
        n_checks++;
        if (q_main.size() !== 2) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes want 2", q_main.size());
        end else begin
            n_checks++;
            if (q_main[0].addr !== 10'(base % 1000) ||
                q_main[0].w !== {pack(f0, 3), pack(f0, 2), pack(f0, 1), pack(f0, 0)}) begin
                n_fail++;
                $display("FAIL bp_frame0: addr=%0d want %0d (or data wrong)", q_main[0].addr, base % 1000);
            end
            n_checks++;
            if (q_main[1].addr !== 10'((base + 1) % 1000) ||
                q_main[1].w !== {pack(f2, 3), pack(f2, 2), pack(f2, 1), pack(f2, 0)}) begin
                n_fail++;
                $display("FAIL bp_frame2: addr=%0d want %0d (or data wrong)", q_main[1].addr, (base + 1) % 1000);
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || frame_cnt !== 10'(n_hs % 1024)) begin
            n_fail++;
            $display("FAIL bp_status: ovf=%b cnt=%0d want 1/%0d", overflow, frame_cnt, n_hs % 1024);
        end
`ifdef IFFT_PACK_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_drop_cnt: got %0d want 1", drop_cnt);
        end
`endif
    endtask

    task automatic test_addr_wrap();
        frame_t f[5];
        do_reset(2);
        q_w4.delete();
        q_main.delete();
        wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) f[i] = rand_frame();
        for (int i = 0; i < 5; i++) drive_frame(f[i]);
        idle(4);
        n_hs = 5;
        n_checks++;
        if (q_w4.size() !== 5) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes want 5", q_w4.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (q_w4[i].addr !== 10'(i % 4) ||
                    q_w4[i].w !== {pack(f[i], 3), pack(f[i], 2), pack(f[i], 1), pack(f[i], 0)}) begin
                    n_fail++;
                    $display("FAIL wrap_write%0d: addr=%0d want %0d (or data wrong)", i, q_w4[i].addr, i % 4);
                end
            end
        end
        n_checks++;
        if (w4_frame_cnt !== 10'd5) begin
            n_fail++;
            $display("FAIL wrap_frame_cnt: got %0d want 5", w4_frame_cnt);
        end
        n_checks++;
        if (q_main.size() !== 5 || wr_addr !== 10'd5) begin
            n_fail++;
            $display("FAIL wrap_main_addr: writes=%0d addr=%0d want 5/5", q_main.size(), wr_addr);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t g, f;
        g = rand_frame();
        f = rand_frame();
        wr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            in_valid = 1'b1;
            set_sample(g, k);
        end
        do_reset(1);
        q_main.delete();
        drive_frame(f);
        idle(4);
        n_hs = 1;
        n_checks++;
        if (q_main.size() !== 1) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d writes want 1", q_main.size());
        end else begin
            n_checks++;
            if (q_main[0].addr !== 10'd0 ||
                q_main[0].w !== {pack(f, 3), pack(f, 2), pack(f, 1), pack(f, 0)}) begin
                n_fail++;
                $display("FAIL midrst_write: addr=%0d want 0 (or data wrong)", q_main[0].addr);
            end
        end
        n_checks++;
        if (frame_cnt !== 10'd1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_status: cnt=%0d ovf=%b want 1/0", frame_cnt, overflow);
        end
    endtask

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        wr_ready = 1'b0;
        in0_re = '0; in0_im = '0; in1_re = '0; in1_im = '0;
        test_reset();
        test_single_frame();
        test_gapped();
        test_back_to_back();
        test_backpressure();
        test_addr_wrap();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
